async_fifo_wr_arb: RTL and testbench
====================================

ASYNC_FIFO_WR_ARB -- requirements
Module: async_fifo_wr_arb

Interface
REQ-001 The block SHALL have parameter DATA_SIZE, default 8, meaning FIFO write-data width in bits.
REQ-002 The block SHALL have parameter NUM_REQ, default 4, meaning number of write requesters (2..8).
REQ-003 The block SHALL have parameter MAX_BURST, default 4, meaning max beats per grant before rotation (1..16).
REQ-004 The block SHALL have port wr_clk, input, 1, the single write-domain clock; all logic is on its rising edge.
REQ-005 The block SHALL have port wr_rstn, input, 1, asynchronous active-low reset.
REQ-006 The block SHALL have port req, input, NUM_REQ, per-requester write request, held high until gnt.
REQ-007 The block SHALL have port req_data, input, NUM_REQ x DATA_SIZE, per-requester write data, stable while req is high.
REQ-008 The block SHALL have port gnt, input-side handshake output, NUM_REQ, one-hot beat-accept pulse.
REQ-009 The block SHALL have port wr_full, input, 1, FIFO full flag.
REQ-010 The block SHALL have port wr_inc, output, 1, FIFO write enable.
REQ-011 The block SHALL have port wr_data, output, DATA_SIZE, FIFO write data.
REQ-012 The block SHALL have port busy, output, 1, high while a burst owner exists.
REQ-013 The block SHALL have port owner_id, output, $clog2(NUM_REQ), index of current owner (0 when idle).
REQ-014 The block SHALL have port stall_cnt, output, 16, count of cycles owner was blocked by wr_full.

Function
REQ-015 The block SHALL implement FSM states IDLE and BURST.
REQ-016 In IDLE, if any req bit is high, the block SHALL select the first requesting index searching upward from last_owner+1 (mod NUM_REQ) and enter BURST next cycle; arbitration latency is exactly 1 cycle.
REQ-017 In IDLE, wr_inc, gnt, busy SHALL be 0 and wr_data SHALL be 0.
REQ-018 In BURST, a beat SHALL be accepted in a cycle iff req[owner]=1 and wr_full=0.
REQ-019 On an accepted beat, wr_inc=1, gnt[owner]=1 (all other gnt bits 0) and wr_data=req_data[owner], combinationally in that cycle.
REQ-020 In BURST with wr_full=1, wr_inc and gnt SHALL be 0 and the beat SHALL be retried each cycle with no loss; wr_data SHALL still show req_data[owner].
REQ-021 A beat counter SHALL increment per accepted beat; on the accept that makes it equal MAX_BURST the FSM SHALL return to IDLE and clear it.
REQ-022 If req[owner]=0 in BURST, the FSM SHALL return to IDLE next cycle with no write that cycle.
REQ-023 On every BURST->IDLE transition, last_owner SHALL be set to owner, guaranteeing round-robin fairness.
REQ-024 wr_inc SHALL never be 1 while wr_full=1.
REQ-025 Requests from non-owners during BURST SHALL be ignored until the next IDLE arbitration.

Reset
REQ-026 Asserting wr_rstn low SHALL immediately force IDLE, beat counter 0, last_owner NUM_REQ-1 (so index 0 wins first), stall_cnt 0, and all outputs 0, including mid-burst.
REQ-027 After deassertion, the first arbitration SHALL occur on the first rising edge with any req high.

Configuration
REQ-028 With macro WR_ARB_STALL_CNT_EN defined, stall_cnt SHALL increment by 1 each BURST cycle with req[owner]=1 and wr_full=1, saturating at 16'hFFFF.
REQ-029 Without WR_ARB_STALL_CNT_EN, stall_cnt SHALL be tied to 0 and no counter register SHALL exist.

Structure
REQ-030 Package async_fifo_pkg SHALL hold the FSM state enum type (IDLE, BURST) and default constants for DATA_SIZE, NUM_REQ, MAX_BURST.
REQ-031 Round-robin selection SHALL be a combinational sub-module rr_pick (inputs req, last_owner; outputs valid, index).

Verification
REQ-032 Reset then req=4'b0001, req_data[0]=8'hA5, wr_full=0 held -> 1 idle cycle, then 4 consecutive wr_inc with wr_data=8'hA5, then IDLE.
REQ-033 req=4'b1111 held, wr_full=0 -> owners 0,1,2,3,0 in order, each 4 beats, 1 idle gap between bursts.
REQ-034 Owner 2 in BURST, wr_full=1 for 3 cycles -> wr_inc=0, gnt=0 for 3 cycles, stall_cnt=3 (macro on) / 0 (macro off), then beats resume with no loss.
REQ-035 Owner 1 drops req after 2 beats while req[3]=1 -> IDLE next cycle, owner 3 granted on following cycle.
REQ-036 wr_rstn low mid-burst after beat 2 -> wr_inc, gnt, busy go 0 immediately; after release req=4'b0110 -> owner 1 first.
REQ-037 MAX_BURST=1, req=4'b0101 -> grants alternate 0,2,0,2, one beat each.

Source files
------------

// File: rtl/async_fifo_pkg.sv
// Shared types and default constants for the FIFO write-side arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package async_fifo_pkg;

  localparam int DEF_DATA_SIZE = 8;
  localparam int DEF_NUM_REQ   = 4;
  localparam int DEF_MAX_BURST = 4;

  // Arbiter FSM: IDLE arbitrates, BURST streams beats from a single owner.
  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_t;

endpackage

// File: rtl/async_fifo_wr_arb_rr_pick.sv
// Round-robin picker: first requesting index searching upward from last_owner+1.
// Latency: purely combinational, 0 cycles.
// Backpressure: none; the caller decides when the pick is consumed.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      last_owner,
  output logic               valid,
  output logic [IW-1:0]      index
);

  localparam logic [IW:0] NR = (IW+1)'(NUM_REQ);

  logic [IW:0] cand;

  // Scan candidates from farthest to nearest so the nearest requester after last_owner wins.
  always_comb begin
    valid = 1'b0;
    index = '0;
    cand  = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      cand = {1'b0, last_owner} + (IW+1)'(i);
      if (cand >= NR) begin
        cand = cand - NR;
      end
      if (req[cand[IW-1:0]]) begin
        valid = 1'b1;
        index = cand[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/async_fifo_wr_arb.sv
// Round-robin write arbiter feeding an async FIFO write port; optional stall counter under WR_ARB_STALL_CNT_EN.
// Latency: 1 cycle idle arbitration, then one beat per cycle combinationally (wr_inc/gnt/wr_data same cycle).
// Backpressure: wr_full holds the current owner's beat (no write, no gnt) and retries it every cycle without loss.
module async_fifo_wr_arb
  import async_fifo_pkg::*;
#(
  parameter int DATA_SIZE = DEF_DATA_SIZE,
  parameter int NUM_REQ   = DEF_NUM_REQ,
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input  logic                              wr_clk,
  input  logic                              wr_rstn,
  input  logic [NUM_REQ-1:0]                req,
  input  logic [NUM_REQ-1:0][DATA_SIZE-1:0] req_data,
  output logic [NUM_REQ-1:0]                gnt,
  input  logic                              wr_full,
  output logic                              wr_inc,
  output logic [DATA_SIZE-1:0]              wr_data,
  output logic                              busy,
  output logic [$clog2(NUM_REQ)-1:0]        owner_id,
  output logic [15:0]                       stall_cnt
);

  localparam int              IW        = $clog2(NUM_REQ);
  localparam logic [IW-1:0]   LAST_RST  = IW'(NUM_REQ - 1);
  localparam logic [4:0]      BEAT_LAST = 5'(MAX_BURST - 1);

  arb_state_t    state_q, state_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [IW-1:0] last_q, last_d;
  logic [4:0]    beat_q, beat_d;

  logic          pick_vld;
  logic [IW-1:0] pick_idx;
  logic          own_req;
  logic          accept;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_rr_pick (
    .req        (req),
    .last_owner (last_q),
    .valid      (pick_vld),
    .index      (pick_idx)
  );

  // Beat acceptance and FIFO-side outputs are combinational on the current owner.
  always_comb begin
    own_req        = req[owner_q];
    accept         = (state_q == BURST) && own_req && !wr_full;
    wr_inc         = accept;
    gnt            = '0;
    gnt[owner_q]   = accept;
    wr_data        = (state_q == BURST) ? req_data[owner_q] : '0;
  end

  assign busy     = (state_q == BURST);
  assign owner_id = owner_q;

  // Next-state: arbitrate in IDLE, count beats in BURST, leave on burst limit or request drop.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    beat_d  = beat_q;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          state_d = BURST;
          owner_d = pick_idx;
          beat_d  = '0;
        end
      end
      BURST: begin
        if (!own_req) begin
          state_d = IDLE;
          last_d  = owner_q;
          owner_d = '0;
          beat_d  = '0;
        end else if (accept) begin
          if (beat_q == BEAT_LAST) begin
            state_d = IDLE;
            last_d  = owner_q;
            owner_d = '0;
            beat_d  = '0;
          end else begin
            beat_d = beat_q + 5'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        owner_d = '0;
        beat_d  = '0;
      end
    endcase
  end

  // FSM registers; reset parks last_owner at the top index so requester 0 wins first.
  always_ff @(posedge wr_clk or negedge wr_rstn) begin
    if (!wr_rstn) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q  <= LAST_RST;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      beat_q  <= beat_d;
    end
  end

`ifdef WR_ARB_STALL_CNT_EN
  logic [15:0] stall_q, stall_d;

  // Count cycles the owner had a beat ready but the FIFO was full; saturates.
  always_comb begin
    stall_d = stall_q;
    if ((state_q == BURST) && own_req && wr_full && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end
  end

  // Stall counter register.
  always_ff @(posedge wr_clk or negedge wr_rstn) begin
    if (!wr_rstn) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_async_fifo_wr_arb.sv
// Self-checking bench: behavioural arbiter model compared every cycle, plus directed literal scenarios.
// Latency: n/a.
// Backpressure: wr_full driven directly and randomly.
module tb_async_fifo_wr_arb;

  localparam int NR = 4;
  localparam int DW = 8;
  localparam int MB = 4;

  logic               wr_clk  = 1'b0;
  logic               wr_rstn = 1'b0;
  logic [NR-1:0]      req     = '0;
  logic [NR-1:0][DW-1:0] req_data;
  logic               wr_full = 1'b0;
  logic [NR-1:0]      gnt;
  logic               wr_inc;
  logic [DW-1:0]      wr_data;
  logic               busy;
  logic [1:0]         owner_id;
  logic [15:0]        stall_cnt;

  logic [NR-1:0]      req2     = '0;
  logic [NR-1:0][DW-1:0] req_data2;
  logic               wr_full2 = 1'b0;
  logic [NR-1:0]      gnt2;
  logic               wr_inc2;
  logic [DW-1:0]      wr_data2;
  logic               busy2;
  logic [1:0]         owner_id2;
  logic [15:0]        stall_cnt2;

  async_fifo_wr_arb #(.DATA_SIZE(DW), .NUM_REQ(NR), .MAX_BURST(MB)) dut (
    .wr_clk(wr_clk), .wr_rstn(wr_rstn), .req(req), .req_data(req_data), .gnt(gnt),
    .wr_full(wr_full), .wr_inc(wr_inc), .wr_data(wr_data), .busy(busy),
    .owner_id(owner_id), .stall_cnt(stall_cnt)
  );

  async_fifo_wr_arb #(.DATA_SIZE(DW), .NUM_REQ(NR), .MAX_BURST(1)) dut_mb1 (
    .wr_clk(wr_clk), .wr_rstn(wr_rstn), .req(req2), .req_data(req_data2), .gnt(gnt2),
    .wr_full(wr_full2), .wr_inc(wr_inc2), .wr_data(wr_data2), .busy(busy2),
    .owner_id(owner_id2), .stall_cnt(stall_cnt2)
  );

  always #5 wr_clk = ~wr_clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model state: who owns the FIFO, how many beats done, who went last.
  bit m_busy  = 1'b0;
  int m_owner = 0;
  int m_beats = 0;
  int m_last  = NR - 1;
  int m_stall = 0;

  logic [NR-1:0] gnt_seen  = '0;
  bit            auto_data = 1'b1;
  bit            q_inc[$];
  int            q_gown[$];
  int            q_gown2[$];
  logic [DW-1:0] q_acc[$];

  // Compare the DUT against the model at every falling edge, then advance the model.
  always @(negedge wr_clk) begin
    logic          e_acc;
    logic [NR-1:0] e_gnt;
    logic [DW-1:0] e_dat;
    int            go;
    int            go2;
    gnt_seen = gnt;
    if (!wr_rstn) begin
      chk("m_busy", busy, 0);
      chk("m_inc", wr_inc, 0);
      chk("m_gnt", gnt, 0);
      chk("m_owner", owner_id, 0);
      chk("m_stall", stall_cnt, 0);
      m_busy = 0; m_owner = 0; m_beats = 0; m_last = NR - 1; m_stall = 0;
    end else begin
      e_acc = m_busy && req[m_owner] && !wr_full;
      e_gnt = e_acc ? NR'(1 << m_owner) : '0;
      e_dat = m_busy ? req_data[m_owner] : '0;
      chk("m_busy", busy, m_busy);
      chk("m_owner", owner_id, m_busy ? m_owner : 0);
      chk("m_inc", wr_inc, e_acc);
      chk("m_gnt", gnt, e_gnt);
      chk("m_data", wr_data, e_dat);
      chk("m_stall", stall_cnt, m_stall);
      if (!m_busy) begin
        for (int k = NR; k >= 1; k--) begin
          if (req[(m_last + k) % NR]) begin
            m_busy  = 1;
            m_owner = (m_last + k) % NR;
          end
        end
        m_beats = 0;
      end else if (!req[m_owner]) begin
        m_busy = 0; m_last = m_owner; m_owner = 0; m_beats = 0;
      end else if (wr_full) begin
`ifdef WR_ARB_STALL_CNT_EN
        if (m_stall < 65535) m_stall++;
`endif
      end else begin
        m_beats++;
        if (m_beats == MB) begin
          m_busy = 0; m_last = m_owner; m_owner = 0; m_beats = 0;
        end
      end
    end
    go = -1; go2 = -1;
    for (int i = 0; i < NR; i++) begin
      if (gnt[i]) go = i;
      if (gnt2[i]) go2 = i;
    end
    q_inc.push_back(wr_inc);
    q_gown.push_back(go);
    q_gown2.push_back(go2);
    if (wr_inc) q_acc.push_back(wr_data);
  end

  task automatic tick();
    @(posedge wr_clk);
    #1;
  endtask

  task automatic clr_logs();
    q_inc.delete(); q_gown.delete(); q_gown2.delete(); q_acc.delete();
  endtask

  task automatic do_reset();
    tick();
    wr_rstn = 1'b0; req = '0; req2 = '0; wr_full = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_inc", wr_inc, 0);
    chk("rst_gnt", gnt, 0);
    chk("rst_owner", owner_id, 0);
    chk("rst_stall", stall_cnt, 0);
    tick(); tick();
    wr_rstn = 1'b1;
  endtask

  // Data driver: a requester presents its next beat after each grant.
  initial begin
    forever begin
      tick();
      if (auto_data) begin
        for (int i = 0; i < NR; i++) begin
          if (gnt_seen[i]) req_data[i] = req_data[i] + 8'd1;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    int exp_g[$];
    for (int i = 0; i < NR; i++) begin
      req_data[i]  = 8'(i * 16);
      req_data2[i] = 8'(8'hC0 + i);
    end

    // Single requester, fixed data: one idle cycle then four writes.
    do_reset();
    auto_data = 0;
    tick(); req = 4'b0001; req_data[0] = 8'hA5; clr_logs();
    repeat (6) tick();
    for (int k = 0; k < 6; k++) chk($sformatf("r032_inc%0d", k), q_inc[k], (k >= 1 && k <= 4) ? 1 : 0);
    chk("r032_acc_n", q_acc.size(), 4);
    for (int k = 0; k < 4; k++) chk($sformatf("r032_dat%0d", k), q_acc[k], 8'hA5);
    req = '0;
    auto_data = 1;

    // All four requesting: rotation 0,1,2,3,0 with one idle gap per burst.
    do_reset();
    tick(); req = 4'b1111; clr_logs();
    repeat (25) tick();
    exp_g.delete();
    for (int b = 0; b < 5; b++) begin
      exp_g.push_back(-1);
      for (int j = 0; j < 4; j++) exp_g.push_back(b % NR);
    end
    for (int k = 0; k < 25; k++) chk($sformatf("r033_gown%0d", k), q_gown[k], exp_g[k]);
    req = '0;

    // Owner 2 blocked by a full FIFO for three cycles, beats resume in order.
    do_reset();
    tick(); req = 4'b0100; req_data[2] = 8'h20; clr_logs();
    tick();
    tick(); wr_full = 1'b1;
    tick(); tick();
    tick(); wr_full = 1'b0;
    repeat (4) tick();
    for (int k = 0; k < 9; k++) chk($sformatf("r034_inc%0d", k), q_inc[k], (k == 1 || k >= 5 && k <= 7) ? 1 : 0);
    for (int k = 0; k < 4; k++) chk($sformatf("r034_dat%0d", k), q_acc[k], 8'(8'h20 + k));
`ifdef WR_ARB_STALL_CNT_EN
    chk("r034_stall", stall_cnt, 3);
`else
    chk("r034_stall", stall_cnt, 0);
`endif
    req = '0;

    // Owner 1 drops after two beats; requester 3 wins after one idle cycle.
    do_reset();
    tick(); req = 4'b1010; clr_logs();
    tick(); tick();
    tick(); req = 4'b1000;
    tick(); tick();
    tick();
    exp_g = '{-1, 1, 1, -1, -1, 3};
    for (int k = 0; k < 6; k++) chk($sformatf("r035_gown%0d", k), q_gown[k], exp_g[k]);
    req = '0;

    // Reset mid-burst after beat 2 clears outputs at once; requester 1 wins afterwards.
    do_reset();
    tick(); req = 4'b0001;
    tick(); tick();
    tick(); wr_rstn = 1'b0;
    #1;
    chk("r036_inc", wr_inc, 0);
    chk("r036_gnt", gnt, 0);
    chk("r036_busy", busy, 0);
    tick(); req = 4'b0110;
    tick(); wr_rstn = 1'b1; clr_logs();
    repeat (3) tick();
    chk("r036_first", q_gown[1], 1);
    req = '0;

    // Single-beat bursts alternate between requesters 0 and 2.
    do_reset();
    tick(); req2 = 4'b0101; clr_logs();
    repeat (8) tick();
    exp_g = '{-1, 0, -1, 2, -1, 0, -1, 2};
    for (int k = 0; k < 8; k++) chk($sformatf("r037_gown%0d", k), q_gown2[k], exp_g[k]);
    req2 = '0;

    // Randomised traffic: requests held until granted (occasional drop), random full, rare reset.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      tick();
      wr_rstn = ($urandom_range(0, 199) != 0);
      for (int i = 0; i < NR; i++) begin
        if (req[i] && !gnt_seen[i]) begin
          if ($urandom_range(0, 19) == 0) req[i] = 1'b0;
        end else begin
          if (!req[i]) req_data[i] = 8'($urandom);
          req[i] = ($urandom_range(0, 2) != 0);
        end
      end
      wr_full = ($urandom_range(0, 3) == 0);
    end
    tick();
    wr_rstn = 1'b1;
    req = '0;
    wr_full = 1'b0;
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
